// File: rtl/mult_acc_pkg.sv
// Shared definitions for the product accumulator: default widths, the
// frame FSM state type and a saturating counter increment.
package mult_acc_pkg;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 9;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mult_product_accumulator.sv
// Accumulates a frame of unsigned products (delimited by in_last) into a
// wide running sum and presents sum, beat count and overflow flag over a
// valid/ready handshake. Build option MULT_ACC_SATURATE_EN clamps the sum
// at all-ones on overflow instead of wrapping.
module mult_product_accumulator
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = mult_acc_pkg::PROD_W,
  parameter int ACC_W  = mult_acc_pkg::ACC_W,
  parameter int CNT_W  = mult_acc_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             beat;
  logic             frame_done;
  logic             handshake;

  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] cnt_add;
  logic             ovf_add;

  // Input acceptance and output handshake qualifiers.
  always_comb begin
    in_ready   = (state == ACCUM) && !clear;
    beat       = in_valid && in_ready;
    frame_done = beat && in_last;
    handshake  = out_valid && out_ready;
  end

  // Post-add values: one extra bit on the adder captures the carry out.
  always_comb begin
    prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    sum_ext  = {1'b0, acc} + prod_ext;
    carry    = sum_ext[ACC_W];
`ifdef MULT_ACC_SATURATE_EN
    // Once clamped, acc is all-ones, so any later non-zero add carries
    // again and zero adds leave it unchanged: the clamp holds for the frame.
    acc_add  = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    acc_add  = sum_ext[ACC_W-1:0];
`endif
    ovf_add  = ovf | carry;
    cnt_add  = CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
  end

  // Next-state logic: leave ACCUM on the last beat, return on handshake.
  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM: if (frame_done) state_next = HOLD;
      HOLD:  if (handshake)  state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Running sum, beat counter and sticky overflow for the open frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == ACCUM) begin
      if (clear || frame_done) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (beat) begin
        acc <= acc_add;
        cnt <= cnt_add;
        ovf <= ovf_add;
      end
    end
  end

  // Result register: loaded on the last beat, held until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (frame_done) begin
      out_valid    <= 1'b1;
      out_sum      <= acc_add;
      out_count    <= cnt_add;
      out_overflow <= ovf_add;
    end else if (handshake) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Self-checking bench for mult_product_accumulator: directed scenarios plus
// randomized frames compared against an arithmetic frame model.
module tb_mult_product_accumulator;

  logic        tb_clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_product;
  logic        in_last;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic [8:0]  out_count;
  logic        out_overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] frame_q[$];
  logic [23:0] exp_sum;
  logic [8:0]  exp_cnt;
  logic        exp_ovf;

  always #5 tb_clk = ~tb_clk;

  mult_product_accumulator #(
    .PROD_W(16),
    .ACC_W (24),
    .CNT_W (9)
  ) dut (
    .clk         (tb_clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_product  (in_product),
    .in_last     (in_last),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_count   (out_count),
    .out_overflow(out_overflow)
  );

  // Frame model: plain integer sum of the frame, then wrap or clamp.
  function automatic void model_frame();
    longint unsigned total = 0;
    foreach (frame_q[i]) total += longint'(frame_q[i]);
    exp_ovf = (total > 64'h0000_0000_00FF_FFFF);
`ifdef MULT_ACC_SATURATE_EN
    exp_sum = exp_ovf ? 24'hFF_FFFF : total[23:0];
`else
    exp_sum = total[23:0];
`endif
    exp_cnt = (frame_q.size() > 511) ? 9'd511 : 9'(frame_q.size());
  endfunction

  // Offer one beat; returns once the accepting edge has passed.
  task automatic drive_beat(input logic [15:0] p, input bit last, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge tb_clk);
      in_valid   = 1'b1;
      in_product = p;
      in_last    = last;
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) in_valid = 1'b0;
    @(posedge tb_clk);
  endtask

  task automatic send_frame(input bit gaps, output int unsigned timeouts);
    bit ok;
    timeouts = 0;
    foreach (frame_q[i]) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(negedge tb_clk);
        in_valid = 1'b0;
      end
      drive_beat(frame_q[i], (i == frame_q.size() - 1), ok);
      if (!ok) timeouts++;
    end
  endtask

  // Wait for a result, capture it and complete the handshake.
  task automatic get_result(output logic [23:0] s, output logic [8:0] c,
                            output logic o, output bit ok);
    ok = 1'b0;
    s  = '0;
    c  = '0;
    o  = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge tb_clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        s  = out_sum;
        c  = out_count;
        o  = out_overflow;
        ok = 1'b1;
        break;
      end
    end
    @(posedge tb_clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0;
    clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    checks++;
    if ({out_valid, out_sum, out_count, out_overflow} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {out_valid, out_sum, out_count, out_overflow});
    end
    rst_n = 1'b1;
    @(negedge tb_clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_basic();
    int unsigned to;
    frame_q = '{16'h0001, 16'h00FF, 16'hFE01};
    send_frame(1'b0, to);
    @(negedge tb_clk);
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    checks++;
    if (to != 0) begin errors++; $display("FAIL basic_accept got %0d timeouts exp 0", to); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b exp 1", out_valid); end
    checks++;
    if (out_sum !== 24'h00FF01) begin errors++; $display("FAIL basic_sum got %h exp 00ff01", out_sum); end
    checks++;
    if (out_count !== 9'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", out_count); end
    checks++;
    if (out_overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", out_overflow); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready got %b exp 0", in_ready); end
    out_ready = 1'b1;
    @(posedge tb_clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int unsigned to;
    logic [23:0] s; logic [8:0] c; logic o; bit ok;
    frame_q.delete();
    for (int i = 0; i < 259; i++) frame_q.push_back(16'hFE01);
    send_frame(1'b0, to);
    get_result(s, c, o, ok);
    checks++;
    if (!ok || to != 0) begin errors++; $display("FAIL ovf_timeout got ok=%b to=%0d exp ok=1 to=0", ok, to); end
`ifdef MULT_ACC_SATURATE_EN
    checks++;
    if (s !== 24'hFFFFFF) begin errors++; $display("FAIL ovf_sum got %h exp ffffff", s); end
`else
    checks++;
    if (s !== 24'h00FB03) begin errors++; $display("FAIL ovf_sum got %h exp 00fb03", s); end
`endif
    checks++;
    if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", o); end
    checks++;
    if (c !== 9'd259) begin errors++; $display("FAIL ovf_count got %0d exp 259", c); end
  endtask

  task automatic test_count_saturate();
    int unsigned to;
    logic [23:0] s; logic [8:0] c; logic o; bit ok;
    frame_q.delete();
    for (int i = 0; i < 515; i++) frame_q.push_back(16'h0000);
    model_frame();
    send_frame(1'b0, to);
    get_result(s, c, o, ok);
    checks++;
    if (!ok || to != 0) begin errors++; $display("FAIL sat_cnt_timeout got ok=%b to=%0d exp ok=1 to=0", ok, to); end
    checks++;
    if (c !== exp_cnt) begin errors++; $display("FAIL sat_cnt_count got %0d exp %0d", c, exp_cnt); end
    checks++;
    if (s !== exp_sum || o !== exp_ovf) begin
      errors++; $display("FAIL sat_cnt_sum got %h/%b exp %h/%b", s, o, exp_sum, exp_ovf);
    end
  endtask

  task automatic test_backpressure();
    int unsigned to;
    frame_q = '{16'h0010, 16'h0010};
    send_frame(1'b0, to);
    checks++;
    if (to != 0) begin errors++; $display("FAIL bp_accept got %0d timeouts exp 0", to); end
    for (int k = 0; k < 5; k++) begin
      @(negedge tb_clk);
      in_valid = 1'b1; in_product = 16'h0099; in_last = 1'b0; out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b exp 1", k, out_valid); end
      checks++;
      if (out_sum !== 24'h000020) begin errors++; $display("FAIL bp_sum cyc %0d got %h exp 000020", k, out_sum); end
      checks++;
      if (out_count !== 9'd2) begin errors++; $display("FAIL bp_count cyc %0d got %0d exp 2", k, out_count); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", k, in_ready); end
    end
    @(negedge tb_clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge tb_clk);
    #1;
    out_ready = 1'b0;
    @(negedge tb_clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_clear();
    logic [23:0] s; logic [8:0] c; logic o; bit ok, ok1, ok2;
    drive_beat(16'h1234, 1'b0, ok1);
    drive_beat(16'h0001, 1'b0, ok2);
    @(negedge tb_clk);
    in_valid = 1'b1; in_product = 16'h7777; in_last = 1'b1; clear = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready got %b exp 0", in_ready); end
    @(posedge tb_clk);
    #1;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    drive_beat(16'h0005, 1'b1, ok);
    get_result(s, c, o, ok);
    checks++;
    if (!ok || !ok1 || !ok2) begin errors++; $display("FAIL clear_timeout got %b%b%b exp 111", ok1, ok2, ok); end
    checks++;
    if (s !== 24'h000005) begin errors++; $display("FAIL clear_sum got %h exp 000005", s); end
    checks++;
    if (c !== 9'd1) begin errors++; $display("FAIL clear_count got %0d exp 1", c); end
    checks++;
    if (o !== 1'b0) begin errors++; $display("FAIL clear_ovf got %b exp 0", o); end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] s; logic [8:0] c; logic o; bit ok;
    for (int i = 0; i < 3; i++) drive_beat(16'h4444, 1'b0, ok);
    @(negedge tb_clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge tb_clk);
    #1;
    checks++;
    if ({out_valid, out_sum, out_count, out_overflow} !== 35'd0) begin
      errors++; $display("FAIL rstmid_during got %h exp 0", {out_valid, out_sum, out_count, out_overflow});
    end
    @(negedge tb_clk);
    rst_n = 1'b1;
    @(posedge tb_clk);
    #1;
    checks++;
    if ({out_valid, out_sum, out_count, out_overflow} !== 35'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_after got %h rdy %b exp 0 rdy 1",
                         {out_valid, out_sum, out_count, out_overflow}, in_ready);
    end
    drive_beat(16'h00AA, 1'b1, ok);
    get_result(s, c, o, ok);
    checks++;
    if (!ok || s !== 24'h0000AA || c !== 9'd1 || o !== 1'b0) begin
      errors++; $display("FAIL rstmid_result got ok=%b %h/%0d/%b exp 1 0000aa/1/0", ok, s, c, o);
    end
    // Reset while a result is pending discards it.
    drive_beat(16'h0042, 1'b1, ok);
    @(negedge tb_clk);
    in_valid = 1'b0; in_last = 1'b0; rst_n = 1'b0;
    @(posedge tb_clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rsthold_valid got %b exp 0", out_valid); end
    @(negedge tb_clk);
    rst_n = 1'b1;
    drive_beat(16'h0003, 1'b1, ok);
    get_result(s, c, o, ok);
    checks++;
    if (!ok || s !== 24'h000003 || c !== 9'd1) begin
      errors++; $display("FAIL rsthold_result got ok=%b %h/%0d exp 1 000003/1", ok, s, c);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    drive_beat(16'h0030, 1'b1, ok);
    @(negedge tb_clk);
    in_valid = 1'b1; in_product = 16'h0002; in_last = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'h000030) begin
      errors++; $display("FAIL b2b_first got %b/%h exp 1/000030", out_valid, out_sum);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_overlap_ready got %b exp 0", in_ready); end
    @(negedge tb_clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_after_hs got valid %b ready %b exp 0 1", out_valid, in_ready);
    end
    @(negedge tb_clk);
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'h000002 || out_count !== 9'd1) begin
      errors++; $display("FAIL b2b_second got %b/%h/%0d exp 1/000002/1", out_valid, out_sum, out_count);
    end
    @(posedge tb_clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int unsigned to, n;
    logic [23:0] s; logic [8:0] c; logic o; bit ok;
    for (int f = 0; f < 8; f++) begin
      frame_q.delete();
      if (f == 3) begin
        n = $urandom_range(300, 340);
        for (int i = 0; i < int'(n); i++) frame_q.push_back(16'($urandom_range(16'hF000, 16'hFFFF)));
      end else begin
        n = $urandom_range(1, 12);
        for (int i = 0; i < int'(n); i++) frame_q.push_back(16'($urandom));
      end
      model_frame();
      send_frame(1'b1, to);
      repeat ($urandom_range(0, 3)) begin
        @(negedge tb_clk);
        in_valid = 1'b0; in_last = 1'b0;
      end
      get_result(s, c, o, ok);
      checks++;
      if (!ok || to != 0) begin errors++; $display("FAIL rand%0d_timeout got ok=%b to=%0d exp 1/0", f, ok, to); end
      checks++;
      if (s !== exp_sum) begin errors++; $display("FAIL rand%0d_sum got %h exp %h", f, s, exp_sum); end
      checks++;
      if (c !== exp_cnt) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", f, c, exp_cnt); end
      checks++;
      if (o !== exp_ovf) begin errors++; $display("FAIL rand%0d_ovf got %b exp %b", f, o, exp_ovf); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_count_saturate();
    test_backpressure();
    test_clear();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
